mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 41 ++++
 rtl/mem_arbiter_lane.sv | 38 +++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types: access masks, arbiter states, memory command payload.
package mem_definitions;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [2:0] {
        MEM_BYTE  = 3'd0,
        MEM_HALF  = 3'd1,
        MEM_WORD  = 3'd2,
        MEM_UBYTE = 3'd3,
        MEM_UHALF = 3'd4
    } mem_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Half needs 2-byte alignment, word needs 4-byte alignment.
    function automatic logic is_misaligned(input mem_mask_t mask, input logic [1:0] lo);
        logic res;
        res = 1'b0;
        case (mask)
            MEM_HALF, MEM_UHALF: res = lo[0];
            MEM_WORD:            res = (lo != 2'b00);
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_lane.sv
// Byte-lane logic: byte enables, store replication, load extraction and extension.
module mem_lane
    import mem_definitions::*;
(
    input  mem_mask_t         mask,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [BE_W-1:0]   be_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   rdata_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        be_c    = 4'b1111;
        wdata_c = wdata;
        rdata_c = rdata;
        case (mask)
            MEM_BYTE, MEM_UBYTE: begin
                be_c    = BE_W'(4'b0001 << addr_lo);
                wdata_c = {4{wdata[7:0]}};
                rdata_c = (mask == MEM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
            end
            MEM_HALF, MEM_UHALF: begin
                be_c    = BE_W'(4'b0011 << addr_lo);
                wdata_c = {2{wdata[15:0]}};
                rdata_c = (mask == MEM_HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'd0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word data accesses are rejected with d_misalign.
module mem_arbiter
    import mem_definitions::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  mem_mask_t         d_mask,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_ready,
    output logic              d_misalign,
    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic [XLEN-1:0]   m_rdata,
    input  logic              m_ack,
    output logic              stall
);

    arb_state_t      state_q, state_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            m_req_q, m_req_d;
    mem_mask_t       mask_q, mask_d;
    logic [1:0]      lo_q, lo_d;
    logic            is_data_q, is_data_d;
    logic            mis_q, mis_d;
    logic            owed_q, owed_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            d_ready_q, d_ready_d;
    logic            d_misalign_q, d_misalign_d;

    mem_mask_t       lane_mask;
    logic [1:0]      lane_lo;
    logic [BE_W-1:0] lane_be_c;
    logic [XLEN-1:0] lane_wdata_c;
    logic [XLEN-1:0] lane_rdata_c;
    logic            mis_c;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_c = is_misaligned(d_mask, d_addr[1:0]);
`else
    assign mis_c = 1'b0;
`endif

    // Lane logic sees the live request at grant and the latched access in RESP.
    always_comb begin
        lane_mask = mask_q;
        lane_lo   = lo_q;
        if (state_q == IDLE) begin
            lane_mask = d_mask;
            lane_lo   = d_addr[1:0];
        end
    end

    mem_lane u_lane (
        .mask    (lane_mask),
        .addr_lo (lane_lo),
        .wdata   (d_wdata),
        .rdata   (rdata_q),
        .be_c    (lane_be_c),
        .wdata_c (lane_wdata_c),
        .rdata_c (lane_rdata_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            m_req_q      <= 1'b0;
            mask_q       <= MEM_WORD;
            lo_q         <= 2'b00;
            is_data_q    <= 1'b0;
            mis_q        <= 1'b0;
            owed_q       <= 1'b0;
            rdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            d_misalign_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            m_req_q      <= m_req_d;
            mask_q       <= mask_d;
            lo_q         <= lo_d;
            is_data_q    <= is_data_d;
            mis_q        <= mis_d;
            owed_q       <= owed_d;
            rdata_q      <= rdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            d_misalign_q <= d_misalign_d;
        end
    end

    // Grants are held off during a ready pulse so a still-high request is not re-issued.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        m_req_d      = m_req_q;
        mask_d       = mask_q;
        lo_d         = lo_q;
        is_data_d    = is_data_q;
        mis_d        = mis_q;
        owed_d       = owed_q;
        rdata_d      = rdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        d_misalign_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!if_ready_q && !d_ready_q) begin
                    if (d_req && !(owed_q && if_req)) begin
                        is_data_d = 1'b1;
                        mask_d    = d_mask;
                        lo_d      = d_addr[1:0];
                        owed_d    = if_req;
                        mis_d     = mis_c;
                        if (mis_c) begin
                            state_d = RESP;
                        end else begin
                            state_d     = DATA;
                            m_req_d     = 1'b1;
                            cmd_d.we    = d_we;
                            cmd_d.be    = lane_be_c;
                            cmd_d.addr  = d_addr & ~XLEN'(3);
                            cmd_d.wdata = d_we ? lane_wdata_c : '0;
                        end
                    end else if (if_req) begin
                        is_data_d   = 1'b0;
                        mis_d       = 1'b0;
                        owed_d      = 1'b0;
                        state_d     = FETCH;
                        m_req_d     = 1'b1;
                        cmd_d.we    = 1'b0;
                        cmd_d.be    = 4'b1111;
                        cmd_d.addr  = if_addr & ~XLEN'(3);
                        cmd_d.wdata = '0;
                    end
                end
            end
            DATA, FETCH: begin
                if (m_ack) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    rdata_d = m_rdata;
                    cmd_d   = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (is_data_q) begin
                    d_ready_d    = 1'b1;
                    d_misalign_d = mis_q;
                    d_rdata_d    = mis_q ? '0 : lane_rdata_c;
                end else begin
                    if_ready_d = 1'b1;
                    if_rdata_d = rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_req      = m_req_q;
    assign m_we       = cmd_q.we;
    assign m_be       = cmd_q.be;
    assign m_addr     = cmd_q.addr;
    assign m_wdata    = cmd_q.wdata;
    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign d_rdata    = d_rdata_q;
    assign d_ready    = d_ready_q;
    assign d_misalign = d_misalign_q;
    assign stall      = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; honours MEM_MISALIGN_CHECK_EN like the RTL.
module tb_mem_arbiter;
    import mem_definitions::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    mem_mask_t   d_mask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_misalign;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_mask     (d_mask),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .d_misalign (d_misalign),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_be       (m_be),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // which: 0 = m_req, 1 = d_ready, 2 = if_ready; bounded wait sampled on negedges.
    task automatic wait_for(input string tag, input int which);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((which == 0 && m_req) || (which == 1 && d_ready) || (which == 2 && if_ready)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic ack_now(input logic [31:0] rdata);
        m_rdata = rdata;
        m_ack   = 1'b1;
        @(negedge clk);
        m_ack   = 1'b0;
    endtask

    task automatic data_txn(input string tag, input logic we, input mem_mask_t mask,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, input logic [31:0] mrdata,
                            input logic [3:0] exp_be, input logic [31:0] exp_mwdata,
                            input logic [31:0] exp_rdata);
        int  cyc;
        bit  seen;
        d_we = we; d_mask = mask; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        cyc = 0;
        @(negedge clk); cyc++;
        check({tag, "_mreq"}, 32'(m_req), 32'd1);
        check({tag, "_maddr"}, m_addr, {addr[31:2], 2'b00});
        check({tag, "_mbe"}, 32'(m_be), 32'(exp_be));
        check({tag, "_mwe"}, 32'(m_we), 32'(we));
        if (we) check({tag, "_mwdata"}, m_wdata, exp_mwdata);
        check({tag, "_stall"}, 32'(stall), 32'd1);
        repeat (delay - 1) begin @(negedge clk); cyc++; end
        check({tag, "_mbe_hold"}, 32'(m_be), 32'(exp_be));
        m_rdata = mrdata; m_ack = 1'b1;
        @(negedge clk); cyc++;
        m_ack = 1'b0;
        check({tag, "_mreq_drop"}, 32'(m_req), 32'd0);
        seen = 1'b0;
        while (!seen && cyc < 30) begin
            if (d_ready) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(delay + 2));
        if (!we) check({tag, "_rdata"}, d_rdata, exp_rdata);
        check({tag, "_misalign"}, 32'(d_misalign), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(d_ready), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_mask = MEM_WORD; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mreq", 32'(m_req), 32'd0);
        check("rst_mwe", 32'(m_we), 32'd0);
        check("rst_mbe", 32'(m_be), 32'd0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_misalign", 32'(d_misalign), 32'd0);
        check("rst_drdata", d_rdata, 32'd0);
        check("rst_maddr", m_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must do nothing.
        ack_now(32'h55555555);
        @(negedge clk);
        check("idle_ack_mreq", 32'(m_req), 32'd0);
        check("idle_ack_ready", {30'd0, if_ready, d_ready}, 32'd0);

        data_txn("lw",  1'b0, MEM_WORD,  32'h100, 32'h0, 2, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        data_txn("lw1", 1'b0, MEM_WORD,  32'h104, 32'h0, 1, 32'h01234567, 4'b1111, 32'h0, 32'h01234567);
        data_txn("lb",  1'b0, MEM_BYTE,  32'h103, 32'h0, 1, 32'h80FFFF00, 4'b1000, 32'h0, 32'hFFFFFF80);
        data_txn("lbu", 1'b0, MEM_UBYTE, 32'h103, 32'h0, 1, 32'h80FFFF00, 4'b1000, 32'h0, 32'h00000080);
        data_txn("lh",  1'b0, MEM_HALF,  32'h100, 32'h0, 3, 32'h80FFFF00, 4'b0011, 32'h0, 32'hFFFFFF00);
        data_txn("lhu", 1'b0, MEM_UHALF, 32'h102, 32'h0, 1, 32'h80FFFF00, 4'b1100, 32'h0, 32'h000080FF);
        data_txn("sh",  1'b1, MEM_HALF,  32'h202, 32'h00001234, 1, 32'h0, 4'b1100, 32'h12341234, 32'h0);
        data_txn("sb",  1'b1, MEM_BYTE,  32'h101, 32'hFFFFFFA5, 1, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        data_txn("sw",  1'b1, MEM_WORD,  32'h300, 32'h89ABCDEF, 2, 32'h0, 4'b1111, 32'h89ABCDEF, 32'h0);

`ifdef MEM_MISALIGN_CHECK_EN
        d_we = 1'b0; d_mask = MEM_WORD; d_addr = 32'h101; d_req = 1'b1;
        @(negedge clk);
        check("mis_mreq", 32'(m_req), 32'd0);
        check("mis_early", 32'(d_ready), 32'd0);
        @(negedge clk);
        check("mis_ready", 32'(d_ready), 32'd1);
        check("mis_flag", 32'(d_misalign), 32'd1);
        check("mis_rdata", d_rdata, 32'd0);
        check("mis_mreq2", 32'(m_req), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        check("mis_pulse", {30'd0, d_ready, d_misalign}, 32'd0);
`else
        data_txn("lwu", 1'b0, MEM_WORD, 32'h101, 32'h0, 1, 32'h5A5A5A5A, 4'b1111, 32'h0, 32'h5A5A5A5A);
        data_txn("lhu1", 1'b0, MEM_HALF, 32'h201, 32'h0, 1, 32'h12345678, 4'b0110, 32'h0, 32'h00003456);
`endif

        // Simultaneous fetch and data, then a new data request: data, fetch, data.
        d_we = 1'b0; d_mask = MEM_WORD; d_addr = 32'h40; d_req = 1'b1;
        if_addr = 32'h80; if_req = 1'b1;
        @(negedge clk);
        check("ord1_maddr", m_addr, 32'h40);
        check("ord1_stall", 32'(stall), 32'd1);
        ack_now(32'h11111111);
        wait_for("ord1_dready", 1);
        check("ord1_rdata", d_rdata, 32'h11111111);
        check("ord1_ifready", 32'(if_ready), 32'd0);
        check("ord1_stall2", 32'(stall), 32'd1);
        d_addr = 32'h44;
        @(negedge clk);
        wait_for("ord2_mreq", 0);
        check("ord2_maddr", m_addr, 32'h80);
        check("ord2_mbe", 32'(m_be), 32'hF);
        check("ord2_mwe", 32'(m_we), 32'd0);
        ack_now(32'hCAFEF00D);
        wait_for("ord2_ifready", 2);
        check("ord2_ifrdata", if_rdata, 32'hCAFEF00D);
        check("ord2_dready", 32'(d_ready), 32'd0);
        check("ord2_stall", 32'(stall), 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        wait_for("ord3_mreq", 0);
        check("ord3_maddr", m_addr, 32'h44);
        ack_now(32'h22222222);
        wait_for("ord3_dready", 1);
        check("ord3_rdata", d_rdata, 32'h22222222);
        d_req = 1'b0;
        @(negedge clk);
        check("ord3_stall", 32'(stall), 32'd0);

        // Reset mid-transaction, then a late ack.
        d_we = 1'b0; d_mask = MEM_WORD; d_addr = 32'h300; d_req = 1'b1;
        @(negedge clk);
        check("rmid_mreq", 32'(m_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; d_req = 1'b0;
        check("rmid_mreq_rst", 32'(m_req), 32'd0);
        m_rdata = 32'h77777777; m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        check("rmid_mreq_ack", 32'(m_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rmid_noready", 32'(d_ready), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
